// File: rtl/uart_tx_fifo_peripheral.sv
// Buffered memory-mapped UART transmitter: DEPTH-entry byte FIFO drained by an 8N1 serializer.
// Define UART_TX_PARITY_EN to add the CTRL.parity_en bit and 8E1 framing.
module uart_tx_fifo_peripheral #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] RESET_DIV = 32'd434
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [1:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        uart_tx
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned L  = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [L-1:0]  level;
    logic          full, empty, overflow;
    logic [31:0]   div;
    logic          tx_en;
`ifdef UART_TX_PARITY_EN
    logic          par_en, par_on, par_bit;
`endif

    state_t        state;
    logic [31:0]   cnt, period;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;

    logic accept, wr, rd, push, push_ok, pop, flush, ovf_clr, bit_done, start_frame, busy;
    logic [31:0] rd_val;

    assign accept   = mem_valid && !mem_ready;
    assign wr       = accept && mem_wstrb[0];
    assign rd       = accept && (mem_wstrb == 4'b0000);
    assign push     = wr && (mem_addr == 2'd1);
    assign ovf_clr  = wr && (mem_addr == 2'd2) && mem_wdata[3];
    assign flush    = wr && (mem_addr == 2'd3) && mem_wdata[1];

    assign full     = (level == L'(DEPTH));
    assign empty    = (level == '0);
    assign busy     = !empty || (state != S_IDLE);
    assign bit_done = (cnt == period - 32'd1);

    // The next frame is loaded straight out of the last STOP cycle so frames run back-to-back.
    assign start_frame = tx_en && !empty &&
                         ((state == S_IDLE) || ((state == S_STOP) && bit_done));
    assign pop         = start_frame;
    assign push_ok     = push && !flush && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            rptr  <= wptr;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok && !pop)      level <= level + 1'b1;
            else if (!push_ok && pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow <= 1'b0;
            div      <= RESET_DIV;
            tx_en    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en   <= 1'b0;
`endif
        end else begin
            if (ovf_clr) overflow <= 1'b0;
            if (push && full && !pop && !flush) overflow <= 1'b1;
            if (wr && (mem_addr == 2'd0)) div <= mem_wdata;
            if (wr && (mem_addr == 2'd3)) begin
                tx_en  <= mem_wdata[0];
`ifdef UART_TX_PARITY_EN
                par_en <= mem_wdata[2];
`endif
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (mem_addr)
            2'd0: rd_val = div;
            2'd2: begin
                rd_val[0]      = busy;
                rd_val[1]      = full;
                rd_val[2]      = empty;
                rd_val[3]      = overflow;
                rd_val[4 +: L] = level;
            end
            2'd3: begin
                rd_val[0] = tx_en;
`ifdef UART_TX_PARITY_EN
                rd_val[2] = par_en;
`endif
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= rd ? rd_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            uart_tx <= 1'b1;
            cnt     <= '0;
            period  <= 32'd2;
            bitcnt  <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par_on  <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else if (start_frame) begin
            shift   <= mem[rptr];
            period  <= (div < 32'd2) ? 32'd2 : div;
            cnt     <= '0;
            bitcnt  <= '0;
            state   <= S_START;
            uart_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_on  <= par_en;
            par_bit <= ^mem[rptr];
`endif
        end else begin
            case (state)
                S_IDLE: uart_tx <= 1'b1;
                S_START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        state   <= S_DATA;
                        uart_tx <= shift[0];
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (par_on) begin
                                state   <= S_PARITY;
                                uart_tx <= par_bit;
                            end else begin
                                state   <= S_STOP;
                                uart_tx <= 1'b1;
                            end
`else
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bitcnt  <= bitcnt + 3'd1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        state   <= S_STOP;
                        uart_tx <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        state   <= S_IDLE;
                        uart_tx <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_peripheral.sv
// Randomized self-checking bench for uart_tx_fifo_peripheral: bus transactions are checked against
// a queue-based FIFO model and the serial line against waveforms built from the byte stream.
module tb_uart_tx_fifo_peripheral;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        uart_tx;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    bit          rec = 1'b0;
    bit          txlog[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  model_q[$];

    uart_tx_fifo_peripheral #(.DEPTH(DEPTH), .RESET_DIV(32'd434)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rec) txlog.push_back(uart_tx);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = 4'hF;
        @(negedge clk);
        check("wr_ready", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wstrb = 4'h0;
        @(negedge clk);
        check("rd_ready", {31'd0, mem_ready}, 32'd1);
        d = mem_rdata;
        mem_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    function automatic logic [31:0] status_of(input int unsigned lvl, input bit ovf, input bit inflight);
        return (lvl << 4) | (32'(ovf) << 3) | (32'(lvl == 0) << 2) |
               (32'(lvl == DEPTH) << 1) | 32'(lvl != 0 || inflight);
    endfunction

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line: idle high, then each byte of exp_bytes as start/data/[parity]/stop, then idle high.
    task automatic check_wave(input string tag, input int unsigned per, input bit par, input int lead);
        bit exp[$];
        int s = -1;
        int unsigned errs = 0;
        foreach (exp_bytes[i]) begin
            repeat (per) exp.push_back(1'b0);
            for (int b = 0; b < 8; b++) repeat (per) exp.push_back(exp_bytes[i][b]);
            if (par) repeat (per) exp.push_back(^exp_bytes[i]);
            repeat (per) exp.push_back(1'b1);
        end
        foreach (txlog[i]) if (s < 0 && txlog[i] == 1'b0) s = i;
        check({tag, "_found"}, 32'(s >= 0), 32'd1);
        if (s >= 0) begin
            if (lead >= 0) check({tag, "_lead"}, 32'(s), 32'(lead));
            for (int k = 0; k < s; k++) if (txlog[k] != 1'b1) errs++;
            foreach (exp[k]) begin
                if (s + k >= txlog.size()) errs++;
                else if (txlog[s + k] != exp[k]) errs++;
            end
            for (int k = s + exp.size(); k < txlog.size(); k++) if (txlog[k] != 1'b1) errs++;
            check({tag, "_wave"}, errs, 32'd0);
        end
    endtask

    task automatic start_rec();
        txlog.delete();
        exp_bytes.delete();
        rec = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int unsigned per, n, dv;
        bit ovf;
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        wait_cycles(3);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        resetn = 1'b1;

        read_check("rst_div", 2'd0, 32'd434);
        read_check("rst_status", 2'd2, 32'h4);
        read_check("rst_ctrl", 2'd3, 32'h1);
        read_check("data_reads0", 2'd1, 32'd0);

        // Single frame, DIV=4, 0x55
        bus_write(2'd0, 32'd4);
        start_rec();
        exp_bytes.push_back(8'h55);
        bus_write(2'd1, 32'h55);
        wait_cycles(50);
        rec = 1'b0;
        check_wave("f55", 4, 1'b0, 2);
        read_check("f55_idle", 2'd2, 32'h4);

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            bus_write(2'd0, d);
            read_check("div_rw", 2'd0, d);
        end

        bus_write(2'd3, 32'h5);
`ifdef UART_TX_PARITY_EN
        read_check("ctrl_par", 2'd3, 32'h5);
`else
        read_check("ctrl_par", 2'd3, 32'h1);
`endif
        bus_write(2'd3, 32'h1);

        // Overflow: 17 pushes with transmitter disabled
        bus_write(2'd0, 32'd2);
        bus_write(2'd3, 32'h0);
        model_q.delete();
        ovf = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = $urandom_range(0, 255);
            if (model_q.size() < DEPTH) model_q.push_back(d[7:0]);
            else ovf = 1'b1;
            bus_write(2'd1, d);
            if (i == 7) read_check("half_status", 2'd2, status_of(model_q.size(), ovf, 1'b0));
        end
        read_check("ovf_status", 2'd2, status_of(model_q.size(), ovf, 1'b0));
        bus_write(2'd2, 32'h8);
        read_check("ovf_clear", 2'd2, status_of(model_q.size(), 1'b0, 1'b0));
        start_rec();
        foreach (model_q[i]) exp_bytes.push_back(model_q[i]);
        bus_write(2'd3, 32'h1);
        wait_cycles(DEPTH * 20 + 20);
        rec = 1'b0;
        check_wave("burst", 2, 1'b0, -1);
        read_check("burst_idle", 2'd2, 32'h4);

        // Flush with a frame in flight
        bus_write(2'd0, 32'd4);
        start_rec();
        exp_bytes.push_back(8'hA5);
        bus_write(2'd1, 32'hA5);
        bus_write(2'd1, 32'h3C);
        bus_write(2'd3, 32'h3);
        read_check("flush_status", 2'd2, 32'h5);
        wait_cycles(90);
        rec = 1'b0;
        check_wave("flush", 4, 1'b0, -1);
        read_check("flush_idle", 2'd2, 32'h4);

        // Random bursts with random divider
        for (int it = 0; it < 5; it++) begin
            dv  = $urandom_range(0, 5);
            per = (dv < 2) ? 2 : dv;
            n   = $urandom_range(1, 4);
            bus_write(2'd0, dv);
            start_rec();
            for (int i = 0; i < n; i++) begin
                d = $urandom_range(0, 255);
                exp_bytes.push_back(d[7:0]);
                bus_write(2'd1, d);
            end
            wait_cycles(n * 10 * per + 20);
            rec = 1'b0;
            check_wave("rand", per, 1'b0, -1);
        end
        read_check("rand_idle", 2'd2, 32'h4);

`ifdef UART_TX_PARITY_EN
        bus_write(2'd3, 32'h5);
        bus_write(2'd0, 32'd2);
        start_rec();
        exp_bytes.push_back(8'h07);
        exp_bytes.push_back(8'h03);
        bus_write(2'd1, 32'h07);
        bus_write(2'd1, 32'h03);
        wait_cycles(70);
        rec = 1'b0;
        check_wave("parity", 2, 1'b1, -1);
        bus_write(2'd3, 32'h1);
`endif

        // Reset mid-frame with DIV=0 (period 2)
        bus_write(2'd0, 32'd0);
        read_check("div0", 2'd0, 32'd0);
        start_rec();
        bus_write(2'd1, 32'h81);
        wait_cycles(8);
        rec = 1'b0;
        begin
            int s = -1;
            logic [4:0] pat = '0;
            foreach (txlog[i]) if (s < 0 && txlog[i] == 1'b0) s = i;
            check("div0_found", 32'(s >= 0), 32'd1);
            if (s >= 0 && s + 5 <= txlog.size()) begin
                for (int k = 0; k < 5; k++) pat = {pat[3:0], txlog[s + k]};
                check("div0_bits", {27'd0, pat}, 32'b00110);
            end
        end
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tx", {31'd0, uart_tx}, 32'd1);
        wait_cycles(2);
        resetn = 1'b1;
        read_check("midrst_div", 2'd0, 32'd434);
        read_check("midrst_status", 2'd2, 32'h4);
        check("midrst_tx_idle", {31'd0, uart_tx}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_peripheral.md
Name: uart_tx_fifo_peripheral

Overview:
- Memory-mapped buffered UART transmitter on the SoC native bus (mem_valid/mem_ready), selected by the top-level address decoder for region 0x0400_xxxx.
- CPU pushes bytes into a DEPTH-entry FIFO without polling per byte; an 8N1 serializer drains the FIFO onto uart_tx.
- Sits downstream of the CPU bus decoder, alongside RAM/UART/GPIO slaves; uart_tx drives the board pin.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >=2.
- RESET_DIV, 434, reset value of the divider register (clk cycles per bit).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- mem_valid  in  1  request, already qualified by the decoder select.
- mem_addr  in  2  word offset (byte address bits [3:2]).
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- mem_ready  out  1  one-cycle response pulse.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Bus: request accepted when mem_valid && !mem_ready. mem_ready=1 exactly on the next cycle, then 0 for at least one cycle. Every request completes in one cycle; there are no wait states.
- Register map:
  - 0x0 DIV: RW 32 bits; reset RESET_DIV; written only when mem_wstrb[0]=1, full word.
  - 0x4 DATA: write with mem_wstrb[0] pushes mem_wdata[7:0]; reads return 0.
  - 0x8 STATUS: read-only except bit3.
    - bit0 busy = FIFO not empty or serializer not IDLE.
    - bit1 full; bit2 empty; bit3 overflow (sticky).
    - bits[4+L-1:4] level, where L = clog2(DEPTH)+1.
    - A write with wstrb[0] and wdata[3]=1 clears overflow.
  - 0xC CTRL: bit0 tx_en (reset 1); bit1 flush (write-1, self-clearing, reads 0); bit2 parity_en (see Optional Feature).
- Reset values: mem_ready=0, mem_rdata=0, uart_tx=1, FIFO empty, overflow=0, serializer IDLE.
- FIFO:
  - Circular buffer, pointers wrap at DEPTH, level 0..DEPTH.
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A push is rejected (data dropped) when full with no pop; this sets overflow.
  - A push and a pop in the same cycle leave level unchanged.
  - Flush sets level=0 and pointers equal. A push in the same cycle as a flush is discarded, and overflow is not set. A frame already in flight completes.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: uart_tx=1. If tx_en and FIFO not empty: load shift register from the head, pop, latch bit_period, go to START. The pop happens on the same clock edge as the transition.
  - bit_period = latched DIV, with values <2 treated as 2. A DIV write mid-frame affects only the next frame.
  - START: uart_tx=0 for bit_period cycles.
  - DATA: 8 bits LSB first, bit_period cycles each; 3-bit bit counter.
  - STOP: uart_tx=1 for bit_period cycles, then IDLE.
  - Back-to-back frames: the next start bit begins the cycle after STOP ends.
- tx_en cleared mid-frame: the current frame finishes; no new pop follows.
- uart_tx is registered; the first start-bit cycle is the cycle after the IDLE->START edge.
- resetn low mid-frame: next edge forces uart_tx=1, FSM to IDLE, FIFO empty, DIV=RESET_DIV.
- Unmapped or disabled fields read as 0.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: CTRL bit2 is RW (reset 0). When set, frames are 8E1: an even-parity bit (XOR of the 8 data bits) is sent between the last data bit and STOP, for bit_period cycles. parity_en is latched at frame start.
- Undefined: CTRL bit2 reads 0, writes are ignored, and frames are always 8N1 with no PARITY state.

Test Plan:
- Reset, then read 0x0/0x8/0xC -> 434, STATUS=0x4 (empty, level 0), CTRL=0x1; uart_tx=1 throughout.
- DIV=4, write DATA=0x55 -> uart_tx: 4 cycles low, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 cycles high (40 cycles total); busy clears afterwards.
- DIV=2, tx_en=0, push 17 bytes -> level 16, full=1, overflow=1, 17th byte lost. Clear overflow -> bit3=0. Set tx_en=1 -> 16 frames back-to-back, no idle gap, FIFO order preserved.
- Push 0xA5, 0x3C, then flush while the first frame is in flight -> 0xA5 completes, 0x3C never sent, level=0 immediately.
- DIV=0 -> bit_period 2. Assert resetn low mid-frame -> uart_tx=1 next cycle, DIV reads 434, level 0.
- With UART_TX_PARITY_EN, parity_en=1, DIV=2: send 0x07 -> parity bit 1 before stop (frame 22 cycles). Send 0x03 -> parity bit 0.
